axi_write_arbiter: RTL and testbench



---
 rtl/axi_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_axi_write_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// Round-robin write arbiter: shares one downstream AXI write path (AW/W/B) among
// NUM_REQ requesters, one outstanding transaction at a time.
module axi_write_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int AXI_ID_WIDTH     = 1,
    parameter int AXI_DATA_WIDTH   = 32,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_AWCHAN_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
    parameter int AXI_WDCHAN_WIDTH = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1,
    parameter int AXI_WBCHAN_WIDTH = AXI_ID_WIDTH + 2
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETN,
    input  logic [NUM_REQ*AXI_AWCHAN_WIDTH-1:0]   S_AXI_AWCH_i,
    input  logic [NUM_REQ-1:0]                    S_AXI_AWCH_VALID_i,
    output logic [NUM_REQ-1:0]                    S_AXI_AWCH_READY_o,
    input  logic [NUM_REQ*AXI_WDCHAN_WIDTH-1:0]   S_AXI_WCH_i,
    input  logic [NUM_REQ-1:0]                    S_AXI_WCH_VALID_i,
    output logic [NUM_REQ-1:0]                    S_AXI_WCH_READY_o,
    output logic [AXI_WBCHAN_WIDTH-1:0]           S_AXI_BCH_o,
    output logic [NUM_REQ-1:0]                    S_AXI_BCH_VALID_o,
    input  logic [NUM_REQ-1:0]                    S_AXI_BCH_READY_i,
    output logic [AXI_AWCHAN_WIDTH-1:0]           M_AXI_AWCH_o,
    output logic                                  M_AXI_AWCH_VALID_o,
    input  logic                                  M_AXI_AWCH_READY_i,
    output logic [AXI_WDCHAN_WIDTH-1:0]           M_AXI_WCH_o,
    output logic                                  M_AXI_WCH_VALID_o,
    input  logic                                  M_AXI_WCH_READY_i,
    input  logic [AXI_WBCHAN_WIDTH-1:0]           M_AXI_BCH_i,
    input  logic                                  M_AXI_BCH_VALID_i,
    output logic                                  M_AXI_BCH_READY_o,
    output logic [NUM_REQ-1:0]                    GRANT_o,
    output logic                                  BUSY_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t state_q, state_d;
    idx_t   grant_idx_q, grant_idx_d;
    idx_t   rr_ptr_q, rr_ptr_d;

    logic   any_req;
    idx_t   arb_idx;
    idx_t   cand_idx;
    int     cand;

    logic [AXI_AWCHAN_WIDTH-1:0] aw_slice [NUM_REQ];
    logic [AXI_WDCHAN_WIDTH-1:0] wd_slice [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign aw_slice[k] = S_AXI_AWCH_i[k*AXI_AWCHAN_WIDTH +: AXI_AWCHAN_WIDTH];
        assign wd_slice[k] = S_AXI_WCH_i[k*AXI_WDCHAN_WIDTH +: AXI_WDCHAN_WIDTH];
    end

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        any_req  = 1'b0;
        arb_idx  = rr_ptr_q;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = idx_t'(cand);
            if (!any_req && S_AXI_AWCH_VALID_i[cand_idx]) begin
                any_req = 1'b1;
                arb_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_idx_d = arb_idx;
                    state_d     = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (S_AXI_AWCH_VALID_i[grant_idx_q] && M_AXI_AWCH_READY_i)
                    state_d = ST_DATA;
            end
            ST_DATA: begin
                // WLAST alone ends the burst; the AW length is never consulted.
                if (S_AXI_WCH_VALID_i[grant_idx_q] && M_AXI_WCH_READY_i &&
                    wd_slice[grant_idx_q][0])
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                if (M_AXI_BCH_VALID_i && S_AXI_BCH_READY_i[grant_idx_q]) begin
                    rr_ptr_d    = (grant_idx_q == idx_t'(NUM_REQ - 1)) ? '0
                                                                        : grant_idx_q + idx_t'(1);
                    grant_idx_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel routing: payloads are muxed freely, valids/readies gated by state.
    always_comb begin
        S_AXI_AWCH_READY_o = '0;
        S_AXI_WCH_READY_o  = '0;
        S_AXI_BCH_VALID_o  = '0;
        GRANT_o            = '0;
        M_AXI_AWCH_VALID_o = 1'b0;
        M_AXI_WCH_VALID_o  = 1'b0;
        M_AXI_BCH_READY_o  = 1'b0;
        M_AXI_AWCH_o       = aw_slice[grant_idx_q];
        M_AXI_WCH_o        = wd_slice[grant_idx_q];
        S_AXI_BCH_o        = M_AXI_BCH_i;
        BUSY_o             = (state_q != ST_IDLE);
        if (state_q != ST_IDLE) GRANT_o[grant_idx_q] = 1'b1;
        unique case (state_q)
            ST_ADDR: begin
                M_AXI_AWCH_VALID_o              = S_AXI_AWCH_VALID_i[grant_idx_q];
                S_AXI_AWCH_READY_o[grant_idx_q] = M_AXI_AWCH_READY_i;
            end
            ST_DATA: begin
                M_AXI_WCH_VALID_o              = S_AXI_WCH_VALID_i[grant_idx_q];
                S_AXI_WCH_READY_o[grant_idx_q] = M_AXI_WCH_READY_i;
            end
            ST_RESP: begin
                S_AXI_BCH_VALID_o[grant_idx_q] = M_AXI_BCH_VALID_i;
                M_AXI_BCH_READY_o              = S_AXI_BCH_READY_i[grant_idx_q];
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Randomized self-checking bench for axi_write_arbiter (NUM_REQ=4) against a
// transaction-level round-robin model.
module tb_axi_write_arbiter;

    localparam int N   = 4;
    localparam int AWW = 46;
    localparam int WDW = 37;
    localparam int WBW = 3;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic [N*AWW-1:0]  S_AXI_AWCH_i;
    logic [N-1:0]      S_AXI_AWCH_VALID_i;
    logic [N-1:0]      S_AXI_AWCH_READY_o;
    logic [N*WDW-1:0]  S_AXI_WCH_i;
    logic [N-1:0]      S_AXI_WCH_VALID_i;
    logic [N-1:0]      S_AXI_WCH_READY_o;
    logic [WBW-1:0]    S_AXI_BCH_o;
    logic [N-1:0]      S_AXI_BCH_VALID_o;
    logic [N-1:0]      S_AXI_BCH_READY_i;
    logic [AWW-1:0]    M_AXI_AWCH_o;
    logic              M_AXI_AWCH_VALID_o;
    logic              M_AXI_AWCH_READY_i;
    logic [WDW-1:0]    M_AXI_WCH_o;
    logic              M_AXI_WCH_VALID_o;
    logic              M_AXI_WCH_READY_i;
    logic [WBW-1:0]    M_AXI_BCH_i;
    logic              M_AXI_BCH_VALID_i;
    logic              M_AXI_BCH_READY_o;
    logic [N-1:0]      GRANT_o;
    logic              BUSY_o;

    int             n_cmp = 0;
    int             n_err = 0;
    int             model_ptr;
    logic [N-1:0]   pend;
    logic [AWW-1:0] aw_pay [N];
    int             won;

    always #5 ACLK = ~ACLK;

    axi_write_arbiter #(.NUM_REQ(N)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWCH_i(S_AXI_AWCH_i), .S_AXI_AWCH_VALID_i(S_AXI_AWCH_VALID_i),
        .S_AXI_AWCH_READY_o(S_AXI_AWCH_READY_o),
        .S_AXI_WCH_i(S_AXI_WCH_i), .S_AXI_WCH_VALID_i(S_AXI_WCH_VALID_i),
        .S_AXI_WCH_READY_o(S_AXI_WCH_READY_o),
        .S_AXI_BCH_o(S_AXI_BCH_o), .S_AXI_BCH_VALID_o(S_AXI_BCH_VALID_o),
        .S_AXI_BCH_READY_i(S_AXI_BCH_READY_i),
        .M_AXI_AWCH_o(M_AXI_AWCH_o), .M_AXI_AWCH_VALID_o(M_AXI_AWCH_VALID_o),
        .M_AXI_AWCH_READY_i(M_AXI_AWCH_READY_i),
        .M_AXI_WCH_o(M_AXI_WCH_o), .M_AXI_WCH_VALID_o(M_AXI_WCH_VALID_o),
        .M_AXI_WCH_READY_i(M_AXI_WCH_READY_i),
        .M_AXI_BCH_i(M_AXI_BCH_i), .M_AXI_BCH_VALID_i(M_AXI_BCH_VALID_i),
        .M_AXI_BCH_READY_o(M_AXI_BCH_READY_o),
        .GRANT_o(GRANT_o), .BUSY_o(BUSY_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first pending requester at or after the pointer.
    function automatic int model_winner();
        for (int i = 0; i < N; i++)
            if (pend[(model_ptr + i) % N]) return (model_ptr + i) % N;
        return -1;
    endfunction

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    task automatic drive_aw();
        for (int k = 0; k < N; k++) S_AXI_AWCH_i[k*AWW +: AWW] = aw_pay[k];
        S_AXI_AWCH_VALID_i = pend;
    endtask

    task automatic add_req(input int k);
        if (!pend[k]) begin
            aw_pay[k] = AWW'({$urandom, $urandom});
            pend[k]   = 1'b1;
        end
    endtask

    // Losing requesters push W beats at all times; none may leak downstream.
    task automatic junk_w(input int win);
        for (int k = 0; k < N; k++) begin
            if (k != win) begin
                S_AXI_WCH_i[k*WDW +: WDW] = WDW'({$urandom, $urandom});
                S_AXI_WCH_VALID_i         = S_AXI_WCH_VALID_i | (N'(1) << k);
            end
        end
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_awvalid"}, M_AXI_AWCH_VALID_o, 0);
        check({tag, "_wvalid"},  M_AXI_WCH_VALID_o, 0);
        check({tag, "_bready"},  M_AXI_BCH_READY_o, 0);
        check({tag, "_awready"}, S_AXI_AWCH_READY_o, 0);
        check({tag, "_wready"},  S_AXI_WCH_READY_o, 0);
        check({tag, "_bvalid"},  S_AXI_BCH_VALID_o, 0);
        check({tag, "_grant"},   GRANT_o, 0);
        check({tag, "_busy"},    BUSY_o, 0);
    endtask

    // One full write from the model's predicted winner. abort_at >= 0 resets
    // the DUT after that many W beats have been accepted.
    task automatic run_txn(input int nbeats, input int aw_stall, input bit wtoggle,
                           input int b_stall, input int abort_at, output int winner);
        int             win;
        int             got;
        int             cyc;
        logic [1:0]     wi;
        logic [N-1:0]   one;
        logic [WDW-1:0] beats [8];
        logic [WBW-1:0] bp;

        win    = model_winner();
        winner = win;
        wi     = 2'(win);
        one    = N'(1) << win;
        for (int b = 0; b < nbeats; b++)
            beats[b] = {(WDW-1)'({$urandom, $urandom}), (b == nbeats - 1)};

        drive_aw();
        S_AXI_WCH_VALID_i = '0;
        junk_w(win);
        S_AXI_WCH_i[win*WDW +: WDW] = beats[0];
        S_AXI_WCH_VALID_i[wi]       = 1'b1;
        M_AXI_AWCH_READY_i = 1'b0;
        M_AXI_WCH_READY_i  = 1'b1;
        #1;
        check("idle_grant", GRANT_o, 0);
        check("idle_awvalid", M_AXI_AWCH_VALID_o, 0);
        check("idle_busy", BUSY_o, 0);
        tick();
        check("grant", GRANT_o, one);
        check("busy", BUSY_o, 1);

        for (int s = 0; s < aw_stall; s++) begin
            check("aw_valid_stall", M_AXI_AWCH_VALID_o, 1);
            check("aw_pay_stall", M_AXI_AWCH_o, aw_pay[win]);
            check("aw_ready_stall", S_AXI_AWCH_READY_o, 0);
            check("early_w_blocked", M_AXI_WCH_VALID_o, 0);
            check("early_wready", S_AXI_WCH_READY_o, 0);
            tick();
        end
        M_AXI_AWCH_READY_i = 1'b1;
        #1;
        check("aw_valid", M_AXI_AWCH_VALID_o, 1);
        check("aw_pay", M_AXI_AWCH_o, aw_pay[win]);
        check("aw_ready", S_AXI_AWCH_READY_o, one);
        check("early_wready_hs", S_AXI_WCH_READY_o, 0);
        tick();
        M_AXI_AWCH_READY_i = 1'b0;
        pend[win] = 1'b0;
        drive_aw();

        got = 0;
        cyc = 0;
        while (got < nbeats && cyc < 200) begin
            if (abort_at >= 0 && got == abort_at) break;
            S_AXI_WCH_VALID_i           = '0;
            junk_w(win);
            S_AXI_WCH_i[win*WDW +: WDW] = beats[got];
            S_AXI_WCH_VALID_i[wi]       = (cyc > 20) || ($urandom_range(0, 3) != 0);
            M_AXI_WCH_READY_i           = wtoggle ? cyc[0] : 1'b1;
            #1;
            check("w_valid", M_AXI_WCH_VALID_o, S_AXI_WCH_VALID_i[wi]);
            check("w_ready", S_AXI_WCH_READY_o, M_AXI_WCH_READY_i ? one : '0);
            if (S_AXI_WCH_VALID_i[wi]) check("w_data", M_AXI_WCH_o, beats[got]);
            if (S_AXI_WCH_VALID_i[wi] && M_AXI_WCH_READY_i) got++;
            tick();
            cyc++;
        end

        if (abort_at >= 0) begin
            ARESETN = 1'b0;
            #1;
            check_all_quiet("abort");
            S_AXI_WCH_VALID_i  = '0;
            M_AXI_WCH_READY_i  = 1'b0;
            pend               = '0;
            drive_aw();
            tick();
            tick();
            ARESETN   = 1'b1;
            model_ptr = 0;
            return;
        end

        // Winner keeps pushing after WLAST: an extra beat must not be accepted.
        S_AXI_WCH_i[win*WDW +: WDW] = WDW'({$urandom, $urandom});
        M_AXI_WCH_READY_i = 1'b1;
        bp                = WBW'($urandom);
        M_AXI_BCH_i       = bp;
        M_AXI_BCH_VALID_i = 1'b1;
        S_AXI_BCH_READY_i = ~one;
        for (int s = 0; s < b_stall; s++) begin
            #1;
            check("b_valid_stall", S_AXI_BCH_VALID_o, one);
            check("b_pay_stall", S_AXI_BCH_o, bp);
            check("b_mready_stall", M_AXI_BCH_READY_o, 0);
            check("resp_no_w", M_AXI_WCH_VALID_o, 0);
            check("resp_no_wready", S_AXI_WCH_READY_o, 0);
            tick();
        end
        S_AXI_BCH_READY_i = '1;
        #1;
        check("b_valid", S_AXI_BCH_VALID_o, one);
        check("b_pay", S_AXI_BCH_o, bp);
        check("b_mready", M_AXI_BCH_READY_o, 1);
        check("resp_grant", GRANT_o, one);
        tick();
        M_AXI_BCH_VALID_i = 1'b0;
        S_AXI_BCH_READY_i = '0;
        S_AXI_WCH_VALID_i = '0;
        M_AXI_WCH_READY_i = 1'b0;
        #1;
        check("done_busy", BUSY_o, 0);
        check("done_grant", GRANT_o, 0);
        check("done_bvalid", S_AXI_BCH_VALID_o, 0);
        model_ptr = (win + 1) % N;
    endtask

    initial begin
        ARESETN            = 1'b0;
        S_AXI_AWCH_i       = '0;
        S_AXI_WCH_i        = '0;
        S_AXI_WCH_VALID_i  = '0;
        S_AXI_BCH_READY_i  = '0;
        M_AXI_AWCH_READY_i = 1'b0;
        M_AXI_WCH_READY_i  = 1'b0;
        M_AXI_BCH_i        = '0;
        M_AXI_BCH_VALID_i  = 1'b0;
        model_ptr          = 0;
        pend               = '0;
        add_req(0);
        add_req(1);
        drive_aw();

        // Reset held with requests pending: everything quiet.
        repeat (3) tick();
        check_all_quiet("reset");
        @(negedge ACLK);
        ARESETN = 1'b1;

        // First grant after reset goes to requester 0, then single write by 1.
        run_txn(2, 0, 1'b0, 0, -1, won);
        check("first_grant_idx", won, 0);
        run_txn(4, 0, 1'b0, 0, -1, won);

        // Lone requester granted back-to-back, then pointer wraps from 3 to 0.
        for (int r = 0; r < 3; r++) begin
            add_req(2);
            run_txn($urandom_range(1, 3), 0, 1'b0, 0, -1, won);
        end
        add_req(3);
        run_txn(1, 0, 1'b0, 0, -1, won);

        // All requesters valid: strict rotation.
        for (int k = 0; k < N; k++) add_req(k);
        for (int i = 0; i < 8; i++) begin
            run_txn(1, 0, 1'b0, 0, -1, won);
            check("fair_order", won, i % N);
            add_req(won);
        end

        // Directed worst-case backpressure, then randomized traffic.
        run_txn(4, 5, 1'b1, 3, -1, won);
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < N; k++) if ($urandom_range(0, 1) != 0) add_req(k);
            if (pend == '0) add_req($urandom_range(0, N - 1));
            run_txn($urandom_range(1, 6), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), -1, won);
        end
        while (pend != '0) run_txn(1, 0, 1'b0, 0, -1, won);

        // Leave the pointer at 2, then reset mid-burst in requester 2's write.
        add_req(1);
        run_txn(1, 0, 1'b0, 0, -1, won);
        add_req(2);
        run_txn(4, 0, 1'b0, 0, 2, won);
        check_all_quiet("post_reset");
        for (int k = 0; k < N; k++) add_req(k);
        run_txn(2, 0, 1'b0, 0, -1, won);
        check("ptr_after_reset", won, 0);
        while (pend != '0) run_txn(1, 1, 1'b1, 1, -1, won);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
